// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback controller.
package regfile_pkg;
  localparam int unsigned BITS_DATA = 32;
  localparam int unsigned BITS_ADDR = 3;
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned REQ_ALU   = 0;
  localparam int unsigned REQ_MEM   = 1;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search begins just after the last winner.
module rr_arbiter import regfile_pkg::*; #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  int unsigned idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last) + k) % N;
      if (!gnt_valid && req[IW'(idx)]) begin
        gnt_valid        = 1'b1;
        gnt[IW'(idx)]    = 1'b1;
        gnt_idx          = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: round-robin writeback arbitration
// plus a busy scoreboard for pending destination registers.
module regfile_wb_arbiter import regfile_pkg::*; #(
  parameter  int unsigned BITS_DATA = regfile_pkg::BITS_DATA,
  parameter  int unsigned BITS_ADDR = regfile_pkg::BITS_ADDR,
  parameter  int unsigned N_REQ     = 2,
  localparam int unsigned NUM_REGS  = 2 ** BITS_ADDR,
  localparam int unsigned IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       reserveValid,
  input  logic [BITS_ADDR-1:0]       reserveAddr,
  output logic                       reserveReady,
  input  logic [N_REQ-1:0]           reqValid,
  input  logic [N_REQ*BITS_ADDR-1:0] reqAddr,
  input  logic [N_REQ*BITS_DATA-1:0] reqData,
  output logic [N_REQ-1:0]           reqReady,
  output logic                       wrEnable,
  output logic [BITS_ADDR-1:0]       dirrInput,
  output logic [BITS_DATA-1:0]       inputData,
  input  logic [BITS_ADDR-1:0]       readAddr1,
  input  logic [BITS_ADDR-1:0]       readAddr2,
  output logic                       readBusy1,
  output logic                       readBusy2,
  output logic [NUM_REGS-1:0]        busyVector,
  output logic                       errUnreserved
);

  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic [IW-1:0]        last_q, last_d;
  logic                 wr_en_q, wr_en_d;
  logic [BITS_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [BITS_DATA-1:0] wr_data_q, wr_data_d;
  logic                 err_q, err_d;

  logic [N_REQ-1:0]     gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_valid;
  logic [BITS_ADDR-1:0] gnt_addr;
  logic [BITS_DATA-1:0] gnt_data;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req       (reqValid),
    .last      (last_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_addr = reqAddr[i*BITS_ADDR +: BITS_ADDR];
        gnt_data = reqData[i*BITS_DATA +: BITS_DATA];
      end
    end
  end

  always_comb begin
    reserveReady = reserveValid && !busy_q[reserveAddr];
    busy_d       = busy_q;
    last_d       = last_q;
    err_d        = err_q;
    wr_en_d      = gnt_valid;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (gnt_valid) begin
      last_d           = gnt_idx;
      wr_addr_d        = gnt_addr;
      wr_data_d        = gnt_data;
      busy_d[gnt_addr] = 1'b0;
      if (!busy_q[gnt_addr]) err_d = 1'b1;
    end
    // Set is applied after clear so a same-address reservation wins.
    if (reserveReady) busy_d[reserveAddr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      last_q    <= IW'(N_REQ - 1);
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      busy_q    <= busy_d;
      last_q    <= last_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign reqReady      = gnt;
  assign wrEnable      = wr_en_q;
  assign dirrInput     = wr_addr_q;
  assign inputData     = wr_data_q;
  assign busyVector    = busy_q;
  assign errUnreserved = err_q;
  assign readBusy1     = busy_q[readAddr1];
  assign readBusy2     = busy_q[readAddr2];

endmodule
